// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 memory subsystem: requester IDs,
// memory geometry and the instruction opcode map.
package mips32_pkg;

  localparam int MEM_AW = 10;
  localparam int MEM_DW = 32;

  // Requester identity carried through the read-return pipe
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_IF   = 2'd1,
    REQ_DM   = 2'd2,
    REQ_DBG  = 2'd3
  } req_id_t;

  // Instruction opcodes of the pipelined core
  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000,
    OP_SUB   = 6'b000001,
    OP_AND   = 6'b000010,
    OP_OR    = 6'b000011,
    OP_SLT   = 6'b000100,
    OP_MUL   = 6'b000101,
    OP_LW    = 6'b001000,
    OP_SW    = 6'b001001,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110,
    OP_HLT   = 6'b111111
  } opcode_t;

endpackage

// File: rtl/mips32_rd_tag_pipe.sv
// Shift register of requester IDs that tracks which port owns the read
// data coming back from the memory DEPTH cycles after issue.
module mips32_rd_tag_pipe
  import mips32_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  req_id_t tag_in,
  output req_id_t tag_out
);

  req_id_t pipe [DEPTH];

  // Shift tags one stage per cycle; reset drops all in-flight reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= REQ_NONE;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign tag_out = pipe[DEPTH-1];

endmodule

// File: rtl/mips32_mem_arbiter.sv
// Shares one synchronous single-port memory among instruction fetch,
// data access and a debug/loader port. Grants are combinational in the
// request cycle; read data returns RD_LAT cycles later to its owner.
//
// Handshake: a requester raises *_req with its payload and holds both
// stable until it sees *_gnt high in the same cycle; the access is issued
// on mem_* in that cycle and the request may be dropped or replaced on
// the following cycle. *_rvalid is a single-cycle strobe qualifying rdata.
module mips32_mem_arbiter
  import mips32_pkg::*;
#(
  parameter int AW           = MEM_AW,
  parameter int DW           = MEM_DW,
  parameter int RD_LAT       = 1,
  parameter int DBG_MAX_WAIT = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              halt_i,
  input  logic                              if_req,
  input  logic [AW-1:0]                     if_addr,
  output logic                              if_gnt,
  output logic                              if_rvalid,
  input  logic                              dm_req,
  input  logic                              dm_we,
  input  logic [AW-1:0]                     dm_addr,
  input  logic [DW-1:0]                     dm_wdata,
  output logic                              dm_gnt,
  output logic                              dm_rvalid,
  input  logic                              dbg_req,
  input  logic                              dbg_we,
  input  logic [AW-1:0]                     dbg_addr,
  input  logic [DW-1:0]                     dbg_wdata,
  output logic                              dbg_gnt,
  output logic                              dbg_rvalid,
  output logic [DW-1:0]                     rdata,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [AW-1:0]                     mem_addr,
  output logic [DW-1:0]                     mem_wdata,
  input  logic [DW-1:0]                     mem_rdata,
  output logic [$clog2(DBG_MAX_WAIT+1)-1:0] dbg_wait_cnt
);

  localparam int WCW = $clog2(DBG_MAX_WAIT + 1);

  req_id_t        winner;
  req_id_t        rd_tag_in;
  req_id_t        rd_tag_out;
  logic [WCW-1:0] wait_cnt;
  logic           dbg_forced;

  assign dbg_forced = (wait_cnt == WCW'(DBG_MAX_WAIT));

  // Pick at most one winner per cycle; nothing is granted during reset
  always_comb begin
    winner = REQ_NONE;
    if (rst_n) begin
      if (halt_i) begin
        if (dbg_req)      winner = REQ_DBG;
        else if (dm_req)  winner = REQ_DM;
        else if (if_req)  winner = REQ_IF;
      end else if (dbg_req && dbg_forced) begin
        winner = REQ_DBG;
      end else begin
        if (dm_req)       winner = REQ_DM;
        else if (if_req)  winner = REQ_IF;
        else if (dbg_req) winner = REQ_DBG;
      end
    end
  end

  assign if_gnt  = (winner == REQ_IF);
  assign dm_gnt  = (winner == REQ_DM);
  assign dbg_gnt = (winner == REQ_DBG);

  // Steer the winner's payload onto the memory port; idle port reads as zero
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (winner)
      REQ_IF: begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      REQ_DM: begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      REQ_DBG: begin
        mem_en    = 1'b1;
        mem_we    = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      default: ;
    endcase
  end

  // Only reads produce return data, so writes travel down the pipe as NONE
  assign rd_tag_in = (mem_en && !mem_we) ? winner : REQ_NONE;

  mips32_rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (rd_tag_in),
    .tag_out (rd_tag_out)
  );

  assign if_rvalid  = rst_n && (rd_tag_out == REQ_IF);
  assign dm_rvalid  = rst_n && (rd_tag_out == REQ_DM);
  assign dbg_rvalid = rst_n && (rd_tag_out == REQ_DBG);
  assign rdata      = (if_rvalid || dm_rvalid || dbg_rvalid) ? mem_rdata : '0;

  // Count consecutive losing debug cycles, saturating at the forcing threshold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!dbg_req || dbg_gnt) begin
      wait_cnt <= '0;
    end else if (!dbg_forced) begin
      wait_cnt <= wait_cnt + WCW'(1);
    end
  end

  assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed plus short random bench for mips32_mem_arbiter. Instance dut
// uses RD_LAT=1 with a behavioural memory; instance dut_b uses RD_LAT=2
// for read pipelining.
module tb_mips32_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A signals ----------------
  logic        halt_i;
  logic        if_req, dm_req, dm_we, dbg_req, dbg_we;
  logic [9:0]  if_addr, dm_addr, dbg_addr;
  logic [31:0] dm_wdata, dbg_wdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0] rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  dbg_wait_cnt;

  // ---------------- instance B signals ----------------
  logic        b_if_req;
  logic [9:0]  b_if_addr;
  logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_dbg_gnt, b_dbg_rvalid;
  logic [31:0] b_rdata;
  logic        b_mem_en, b_mem_we;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_dbg_wait_cnt;

  mips32_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .halt_i(halt_i),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_wait_cnt(dbg_wait_cnt)
  );

  mips32_mem_arbiter #(.RD_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .halt_i(1'b0),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(10'd0), .dm_wdata(32'd0),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(10'd0), .dbg_wdata(32'd0),
    .dbg_gnt(b_dbg_gnt), .dbg_rvalid(b_dbg_rvalid),
    .rdata(b_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .dbg_wait_cnt(b_dbg_wait_cnt)
  );

  // ---------------- memory contents ----------------
  function automatic logic [31:0] init_val(input logic [9:0] a);
    return 32'h1357_0000 + 32'(a) * 32'd7;
  endfunction

  function automatic logic [31:0] fb(input logic [9:0] a);
    return 32'hCAFE_0000 ^ {22'd0, a};
  endfunction

  // Memory A: 1-cycle synchronous single-port RAM
  logic [31:0] mem_a [int];
  logic [31:0] rd_a;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_a[int'(mem_addr)] = mem_wdata;
      else rd_a = mem_a.exists(int'(mem_addr)) ? mem_a[int'(mem_addr)] : init_val(mem_addr);
    end
  end
  assign mem_rdata = rd_a;

  // Memory B: 2-cycle read-only ROM
  logic [31:0] rd_b1, rd_b2;
  always @(posedge clk) begin
    rd_b2 <= rd_b1;
    if (b_mem_en) rd_b1 <= fb(b_mem_addr);
  end
  assign b_mem_rdata = rd_b2;

  // ---------------- checking ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  // Reference store: only addresses written through the arbiter
  logic [31:0] ref_w [int];
  function automatic logic [31:0] exp_val(input logic [9:0] a);
    return ref_w.exists(int'(a)) ? ref_w[int'(a)] : init_val(a);
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  logic [31:0] exp_dbg_q[$];
  logic [31:0] exp_b_q[$];

  // Instance A: per-cycle grant sanity, pop returns, push accepted reads
  always @(negedge clk) begin
    check("one_gnt", 32'($countones({if_gnt, dm_gnt, dbg_gnt}) <= 1), 32'd1);
    check1("mem_en_vs_gnt", mem_en, if_gnt | dm_gnt | dbg_gnt);
    if (!rst_n) begin
      exp_if_q.delete();
      exp_dm_q.delete();
      exp_dbg_q.delete();
    end else begin
      if (if_rvalid) begin
        check("if_rvalid_expected", 32'(exp_if_q.size() != 0), 32'd1);
        if (exp_if_q.size() != 0) check("if_rdata", rdata, exp_if_q.pop_front());
      end
      if (dm_rvalid) begin
        check("dm_rvalid_expected", 32'(exp_dm_q.size() != 0), 32'd1);
        if (exp_dm_q.size() != 0) check("dm_rdata", rdata, exp_dm_q.pop_front());
      end
      if (dbg_rvalid) begin
        check("dbg_rvalid_expected", 32'(exp_dbg_q.size() != 0), 32'd1);
        if (exp_dbg_q.size() != 0) check("dbg_rdata", rdata, exp_dbg_q.pop_front());
      end
      if (if_gnt) exp_if_q.push_back(exp_val(if_addr));
      if (dm_gnt) begin
        if (dm_we) ref_w[int'(dm_addr)] = dm_wdata;
        else exp_dm_q.push_back(exp_val(dm_addr));
      end
      if (dbg_gnt) begin
        if (dbg_we) ref_w[int'(dbg_addr)] = dbg_wdata;
        else exp_dbg_q.push_back(exp_val(dbg_addr));
      end
    end
  end

  // Instance B: fetch returns must come back in grant order
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_b_q.delete();
    end else begin
      if (b_if_rvalid) begin
        check("b_rvalid_expected", 32'(exp_b_q.size() != 0), 32'd1);
        if (exp_b_q.size() != 0) check("b_if_rdata", b_rdata, exp_b_q.pop_front());
      end
      if (b_if_gnt) exp_b_q.push_back(fb(b_if_addr));
    end
  end

  // ---------------- driver helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    if_req  = 1'b0;
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    dbg_req = 1'b0;
    dbg_we  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  logic        gi, gm, gd;
  logic [31:0] wr_val;

  initial begin
    rst_n     = 1'b0;
    halt_i    = 1'b0;
    if_req    = 1'b1; if_addr  = 10'd3;
    dm_req    = 1'b1; dm_we    = 1'b0; dm_addr  = 10'd7; dm_wdata  = 32'd0;
    dbg_req   = 1'b1; dbg_we   = 1'b0; dbg_addr = 10'd9; dbg_wdata = 32'd0;
    b_if_req  = 1'b0; b_if_addr = 10'd0;

    // 1. Reset with every requester active
    repeat (3) begin
      @(negedge clk);
      check("rst_gnts", {29'd0, if_gnt, dm_gnt, dbg_gnt}, 32'd0);
      check("rst_rvalids", {29'd0, if_rvalid, dm_rvalid, dbg_rvalid}, 32'd0);
      check("rst_mem_ctl", {30'd0, mem_en, mem_we}, 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_wait_cnt", 32'(dbg_wait_cnt), 32'd0);
    end
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_gnts", {29'd0, if_gnt, dm_gnt, dbg_gnt}, 32'b010);
    cyc();
    idle_all();
    @(negedge clk);
    check1("rel_dm_rvalid", dm_rvalid, 1'b1);
    repeat (2) cyc();

    // 2. Contention between fetch and data
    if_req = 1'b1; if_addr = 10'd5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd200;
    @(negedge clk);
    check("cont_n_gnts", {30'd0, if_gnt, dm_gnt}, 32'b01);
    cyc();
    dm_req = 1'b0;
    @(negedge clk);
    check("cont_n1_gnts", {30'd0, if_gnt, dm_gnt}, 32'b10);
    check1("cont_dm_rvalid", dm_rvalid, 1'b1);
    check("cont_dm_rdata", rdata, init_val(10'd200));
    cyc();
    if_req = 1'b0;
    @(negedge clk);
    check1("cont_if_rvalid", if_rvalid, 1'b1);
    check("cont_if_rdata", rdata, init_val(10'd5));
    cyc();

    // 3. Debug starvation guard against continuous data traffic
    dm_req  = 1'b1; dm_we  = 1'b0; dm_addr  = 10'd20;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd21;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check1("starve_dbg_gnt", dbg_gnt, (c == 9) || (c == 18));
      check1("starve_dm_gnt", dm_gnt, !((c == 9) || (c == 18)));
      check("starve_wait_cnt", 32'(dbg_wait_cnt), 32'((c - 1) % 9));
      cyc();
    end
    idle_all();
    cyc();
    @(negedge clk);
    check("starve_wait_clear", 32'(dbg_wait_cnt), 32'd0);
    cyc();

    // 4. Program result stored by the core, then halted debug load/readback
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd198; dm_wdata = 32'd5040;
    @(negedge clk);
    check1("res_dm_gnt", dm_gnt, 1'b1);
    cyc();
    idle_all();
    halt_i = 1'b1;
    if_req = 1'b1; if_addr = 10'd40;
    for (int i = 0; i <= 10; i++) begin
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'(i); dbg_wdata = 32'(i * 11 + 100);
      @(negedge clk);
      check("halt_wr_gnts", {30'd0, if_gnt, dbg_gnt}, 32'b01);
      cyc();
    end
    dbg_we = 1'b0; dbg_addr = 10'd198;
    @(negedge clk);
    check("halt_rd_gnts", {30'd0, if_gnt, dbg_gnt}, 32'b01);
    cyc();
    dbg_req = 1'b0;
    @(negedge clk);
    check1("halt_if_gnt", if_gnt, 1'b1);
    check1("halt_dbg_rvalid", dbg_rvalid, 1'b1);
    check("halt_dbg_rdata", rdata, 32'd5040);
    cyc();
    if_req = 1'b0;
    // Write immediately followed by a read of the same word
    wr_val = $urandom;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd300; dm_wdata = wr_val;
    @(negedge clk);
    check1("raw_wr_gnt", dm_gnt, 1'b1);
    cyc();
    dm_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd300;
    @(negedge clk);
    check1("raw_rd_gnt", dbg_gnt, 1'b1);
    cyc();
    dbg_req = 1'b0;
    @(negedge clk);
    check("raw_rdata", rdata, wr_val);
    cyc();
    halt_i = 1'b0;
    // Debug memory image readback
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'd4;
    @(negedge clk);
    check1("img_rd_gnt", dbg_gnt, 1'b1);
    cyc();
    dbg_req = 1'b0;
    @(negedge clk);
    check("img_rdata", rdata, 32'd144);
    cyc();

    // 5. Back-to-back fetches through the 2-deep read pipe
    b_if_req = 1'b1; b_if_addr = 10'd10;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      check1("pipe_gnt", b_if_gnt, c < 4);
      check1("pipe_rvalid", b_if_rvalid, (c >= 2) && (c < 6));
      cyc();
      b_if_addr = 10'(11 + c);
      b_if_req  = (c + 1) < 4;
    end

    // 6. Reset one cycle after a data read is granted
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd50;
    @(negedge clk);
    check1("mid_rst_dm_gnt", dm_gnt, 1'b1);
    cyc();
    dm_req = 1'b0;
    rst_n  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check1("mid_rst_dm_rvalid", dm_rvalid, 1'b0);
      cyc();
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check1("post_rst_dm_rvalid", dm_rvalid, 1'b0);
      cyc();
    end

    // Random mixed traffic with hold-until-grant requesters
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      gi = if_gnt; gm = dm_gnt; gd = dbg_gnt;
      cyc();
      halt_i = ($urandom_range(0, 3) == 0);
      if (!if_req || gi) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = 10'($urandom_range(0, 15));
      end
      if (!dm_req || gm) begin
        dm_req   = 1'($urandom_range(0, 1));
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = 10'($urandom_range(0, 15));
        dm_wdata = $urandom;
      end
      if (!dbg_req || gd) begin
        dbg_req   = 1'($urandom_range(0, 1));
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 10'($urandom_range(0, 15));
        dbg_wdata = $urandom;
      end
    end
    // Let the last granted requests complete, then go idle
    @(negedge clk);
    gi = if_gnt; gm = dm_gnt; gd = dbg_gnt;
    cyc();
    idle_all();
    halt_i = 1'b0;
    repeat (4) cyc();

    // Every expected return must have arrived
    @(negedge clk);
    check("drain_if_q", 32'(exp_if_q.size()), 32'd0);
    check("drain_dm_q", 32'(exp_dm_q.size()), 32'd0);
    check("drain_dbg_q", 32'(exp_dbg_q.size()), 32'd0);
    check("drain_b_q", 32'(exp_b_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
